// File: rtl/stepper_pkg.sv
// Shared types and defaults for the per-motor stepper stage.
//   state_t      : axis controller states
//   POS_W_DEF    : default position/target width (binary step count)
//   MAX_POS_DEF  : default highest legal coordinate (3-digit entry)
//   SEL_*        : half-period select codes understood by step_timer
package stepper_pkg;

  typedef enum logic [2:0] {
    UNHOMED,
    HOMING,
    READY,
    MOVE,
    FAULT
  } state_t;

  localparam int unsigned POS_W_DEF   = 10;
  localparam int unsigned MAX_POS_DEF = 999;

  localparam logic [1:0] SEL_X1 = 2'd0;  // half-period = HALF
  localparam logic [1:0] SEL_X2 = 2'd1;  // half-period = 2*HALF
  localparam logic [1:0] SEL_X4 = 2'd2;  // half-period = 4*HALF

endpackage

// File: rtl/step_timer.sv
// Step pulse phase generator.
// Each period is a low phase followed by a high phase of equal length; the
// low phase doubles as direction setup time. A step completes at the wrap.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   run   : count while high; counter held at zero otherwise
//   clear : restart the period from the low phase
//   sel   : half-period select (SEL_X1 / SEL_X2 / SEL_X4 times HALF)
//   pu    : step pulse, high during the second half of the period
//   done  : one-cycle strobe on the last cycle of a period (PU falling edge)
module step_timer
  import stepper_pkg::*;
#(
  parameter int unsigned HALF = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clear,
  input  logic [1:0] sel,
  output logic       pu,
  output logic       done
);

  localparam int unsigned CW = $clog2(8 * HALF);

  logic [CW-1:0] cnt;
  logic [CW-1:0] half_len;
  logic [CW-1:0] last;

  always_comb begin
    case (sel)
      SEL_X2: begin
        half_len = CW'(2 * HALF);
        last     = CW'(4 * HALF - 1);
      end
      SEL_X4: begin
        half_len = CW'(4 * HALF);
        last     = CW'(8 * HALF - 1);
      end
      default: begin
        half_len = CW'(HALF);
        last     = CW'(2 * HALF - 1);
      end
    endcase
  end

  assign done = run && (cnt == last);
  assign pu   = run && (cnt >= half_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !run || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/stepper_axis.sv
// Per-motor motion stage: homes against the Stop limit switch, tracks the
// absolute position in steps and steps to each committed target.
// Optional build macro STEPPER_RAMP_EN: acceleration ramp (4x, 2x, 1x HALF)
// on every move start and direction reversal; homing then runs at 2x HALF.
//   sysclk      : system clock
//   reset       : asynchronous active-high reset
//   stop        : raw limit switch (asynchronous, active high)
//   home_req    : one-cycle pulse, start/restart homing (aborts anything)
//   target      : committed coordinate
//   target_load : one-cycle pulse, latch target
//   PU / DR / MF: step pulse, direction (1 = away from home), motor free
//   pos         : absolute position
//   busy        : homing or moving
//   homed       : position valid
//   err         : sticky; homing timeout or rejected target
module stepper_axis
  import stepper_pkg::*;
#(
  parameter int unsigned POS_W    = POS_W_DEF,
  parameter int unsigned MAX_POS  = MAX_POS_DEF,
  parameter int unsigned HALF     = 500,
  parameter int unsigned HOME_MAX = 1023
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             stop,
  input  logic             home_req,
  input  logic [POS_W-1:0] target,
  input  logic             target_load,
  output logic             PU,
  output logic             DR,
  output logic             MF,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             homed,
  output logic             err
);

  localparam int unsigned HW = $clog2(HOME_MAX + 1);

  state_t           state, state_n;
  logic             stop_m, stop_s;
  logic [POS_W-1:0] tgt, tgt_n, pos_n, step_pos, eff_tgt;
  logic             dr_n, homed_n, err_n;
  logic [HW-1:0]    hcnt, hcnt_n;
  logic             run, tmr_clear, step_done, tgt_ok;
  logic [1:0]       sel;

`ifdef STEPPER_RAMP_EN
  logic [1:0] rcnt, rcnt_n;  // steps since move start / reversal, saturates at 2

  always_comb begin
    if (state == HOMING) begin
      sel = SEL_X2;
    end else begin
      case (rcnt)
        2'd0:    sel = SEL_X4;
        2'd1:    sel = SEL_X2;
        default: sel = SEL_X1;
      endcase
    end
  end
`else
  assign sel = SEL_X1;
`endif

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      stop_m <= 1'b0;
      stop_s <= 1'b0;
    end else begin
      stop_m <= stop;
      stop_s <= stop_m;
    end
  end

  assign run       = (state == HOMING) || (state == MOVE);
  // Every state entry (and a homing restart) begins with a fresh low phase.
  assign tmr_clear = home_req || (state_n != state);
  assign MF        = (state == UNHOMED) || (state == FAULT);
  assign busy      = run;
  assign tgt_ok    = (target <= POS_W'(MAX_POS));
  assign step_pos  = DR ? pos + POS_W'(1) : pos - POS_W'(1);

  step_timer #(
    .HALF(HALF)
  ) u_timer (
    .clk  (sysclk),
    .rst  (reset),
    .run  (run),
    .clear(tmr_clear),
    .sel  (sel),
    .pu   (PU),
    .done (step_done)
  );

  always_comb begin
    state_n = state;
    pos_n   = pos;
    tgt_n   = tgt;
    dr_n    = DR;
    hcnt_n  = hcnt;
    homed_n = homed;
    err_n   = err;
    eff_tgt = tgt;
`ifdef STEPPER_RAMP_EN
    rcnt_n  = rcnt;
`endif
    if (home_req) begin
      state_n = HOMING;
      dr_n    = 1'b0;
      hcnt_n  = '0;
      homed_n = 1'b0;
    end else begin
      case (state)
        UNHOMED: begin
          if (target_load) err_n = 1'b1;
        end
        HOMING: begin
          dr_n = 1'b0;
          if (stop_s) begin
            pos_n   = '0;
            homed_n = 1'b1;
            err_n   = 1'b0;
            state_n = READY;
          end else if (step_done) begin
            if (hcnt == HW'(HOME_MAX - 1)) begin
              state_n = FAULT;
              err_n   = 1'b1;
            end else begin
              hcnt_n = hcnt + HW'(1);
            end
          end
        end
        READY: begin
          if (target_load) begin
            if (!tgt_ok) begin
              err_n = 1'b1;
            end else if (target != pos) begin
              tgt_n   = target;
              dr_n    = (target > pos);
              state_n = MOVE;
`ifdef STEPPER_RAMP_EN
              rcnt_n  = '0;
`endif
            end
          end
        end
        MOVE: begin
          if (stop_s && !DR) begin
            pos_n   = '0;
            state_n = READY;
          end else begin
            // A retarget landing on the completion cycle is honoured by it.
            if (target_load) begin
              if (tgt_ok) begin
                eff_tgt = target;
                tgt_n   = target;
              end else begin
                err_n = 1'b1;
              end
            end
            if (step_done) begin
              pos_n = step_pos;
              // pos == eff_tgt: retargeted onto the position the in-flight
              // step was leaving; end the move at this completion.
              if ((step_pos == eff_tgt) || (pos == eff_tgt)) begin
                state_n = READY;
              end else begin
                dr_n = (eff_tgt > step_pos);
`ifdef STEPPER_RAMP_EN
                if (dr_n != DR) rcnt_n = '0;
                else if (rcnt != 2'd2) rcnt_n = rcnt + 2'd1;
`endif
              end
            end
          end
        end
        FAULT: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= UNHOMED;
      pos   <= '0;
      tgt   <= '0;
      DR    <= 1'b0;
      hcnt  <= '0;
      homed <= 1'b0;
      err   <= 1'b0;
`ifdef STEPPER_RAMP_EN
      rcnt  <= '0;
`endif
    end else begin
      state <= state_n;
      pos   <= pos_n;
      tgt   <= tgt_n;
      DR    <= dr_n;
      hcnt  <= hcnt_n;
      homed <= homed_n;
      err   <= err_n;
`ifdef STEPPER_RAMP_EN
      rcnt  <= rcnt_n;
`endif
    end
  end

endmodule
